// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes,
// ALU operation classes and the datapath select codes.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Extender select depends only on the opcode, so it is valid in every state.
  function automatic logic [1:0] immsrc_of(input logic [6:0] op);
    case (op)
      OP_LW, OP_I: return IMM_I;
      OP_SW:       return IMM_S;
      OP_BEQ:      return IMM_B;
      OP_JAL:      return IMM_J;
      default:     return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_controller_aludec.sv
// Combinational ALU decoder: maps the FSM's operation class and the
// instruction funct fields onto the ALU control code.
module aludec
  import riscv_mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // instr[30] selects sub only for register-register ops; addi ignores it.
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control unit (lw, sw, R/I ALU, beq, jal): Moore FSM driving
// the shared ALU, memory port, register file and PC enables.
module riscv_mc_controller
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t state_reg;
  state_t state_next;
  aluop_t aluop;
  logic   pcupdate;
  logic   branch;
  logic   irwrite_raw;
  logic   regwrite_raw;
  logic   memwrite_raw;
  logic   illegal_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = S_FETCH;
    aluop        = ALUOP_ADD;
    alusrca      = SRCA_PC;
    alusrcb      = SRCB_REGB;
    resultsrc    = RES_ALUOUT;
    adrsrc       = 1'b0;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    case (state_reg)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        alusrcb     = SRCB_FOUR;
        resultsrc   = RES_ALURESULT;
        pcupdate    = 1'b1;
        state_next  = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut while decoding.
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default: begin
            illegal_raw = 1'b1;
            state_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = SRCA_REGA;
        alusrcb    = SRCB_IMM;
        state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc     = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc    = RES_DATA;
        regwrite_raw = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
        state_next   = S_FETCH;
      end
      S_EXECUTER: begin
        alusrca    = SRCA_REGA;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        state_next   = S_FETCH;
      end
      S_EXECUTEI: begin
        alusrca    = SRCA_REGA;
        alusrcb    = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_JAL: begin
        // Link value OldPC+4 is formed here while the PC takes the target from ALUOut.
        alusrca    = SRCA_OLDPC;
        alusrcb    = SRCB_FOUR;
        pcupdate   = 1'b1;
        state_next = S_ALUWB;
      end
      S_BEQ: begin
        alusrca    = SRCA_REGA;
        aluop      = ALUOP_SUB;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  aludec u_aludec (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

  assign immsrc    = immsrc_of(op);
  assign state_dbg = state_reg;

  // Enables are gated by reset so an aborted instruction never commits.
  assign irwrite  = irwrite_raw & ~reset;
  assign pcwrite  = (pcupdate | (branch & zero)) & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign memwrite = memwrite_raw & ~reset;
  assign illegal  = illegal_raw & ~reset;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Cycle-by-cycle check of the multicycle controller: every stimulus row carries
// the full expected output bundle, queued at drive time and compared mid-cycle.
module tb_riscv_mc_controller;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] ILL0 = 7'b0000000;
  localparam logic [6:0] ILL1 = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite;
  logic       pcwrite;
  logic       regwrite;
  logic       memwrite;
  logic       illegal;
  logic [3:0] state_dbg;

  riscv_mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .immsrc     (immsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .resultsrc  (resultsrc),
    .adrsrc     (adrsrc),
    .alucontrol (alucontrol),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .illegal    (illegal),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [20:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [20:0] exp;
  } sb_t;

  vec_t tbl[80];
  int   n_rows = 0;
  sb_t  q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Bundle layout: state|immsrc|alusrca|alusrcb|resultsrc|adrsrc|alucontrol|ir,pc,rw,mw,ill
  function automatic logic [20:0] x(input int st, input int imm, input int sa, input int sb,
                                    input int rs, input int adr, input int alu,
                                    input logic [4:0] en);
    return {st[3:0], imm[1:0], sa[1:0], sb[1:0], rs[1:0], adr[0], alu[2:0], en};
  endfunction

  task automatic add(input string nm, input int rst, input logic [6:0] o, input int f3,
                     input int f7, input int z, input logic [20:0] e);
    tbl[n_rows].name = nm;
    tbl[n_rows].rst  = rst[0];
    tbl[n_rows].op   = o;
    tbl[n_rows].f3   = f3[2:0];
    tbl[n_rows].f7   = f7[0];
    tbl[n_rows].z    = z[0];
    tbl[n_rows].exp  = e;
    n_rows++;
  endtask

  task automatic step(input vec_t v);
    sb_t s;
    reset    = v.rst;
    op       = v.op;
    funct3   = v.f3;
    funct7b5 = v.f7;
    zero     = v.z;
    s.name   = v.name;
    s.exp    = v.exp;
    q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      sb_t s;
      logic [20:0] act;
      s   = q.pop_front();
      act = {state_dbg, immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
             irwrite, pcwrite, regwrite, memwrite, illegal};
      n_checks++;
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got %b_%b_%b_%b_%b_%b_%b_%b want %b_%b_%b_%b_%b_%b_%b_%b",
                 s.name, act[20:17], act[16:15], act[14:13], act[12:11], act[10:9], act[8],
                 act[7:5], act[4:0], s.exp[20:17], s.exp[16:15], s.exp[14:13],
                 s.exp[12:11], s.exp[10:9], s.exp[8], s.exp[7:5], s.exp[4:0]);
      end else begin
        $display("ok   %s state=%0d", s.name, act[20:17]);
      end
    end
  end

  initial begin
    // Reset held two cycles: FETCH selects visible, every enable suppressed.
    add("rst0", 1, LW, 2, 0, 0, x(0, 0, 0, 2, 2, 0, 0, 5'b00000));
    add("rst1", 1, LW, 2, 0, 0, x(0, 0, 0, 2, 2, 0, 0, 5'b00000));
    // lw 0x0043ae03, with zero toggling in non-branch states
    add("lw_fetch", 0, LW, 2, 0, 0, x(0, 0, 0, 2, 2, 0, 0, 5'b11000));
    add("lw_dec",   0, LW, 2, 0, 1, x(1, 0, 1, 1, 0, 0, 0, 5'b00000));
    add("lw_adr",   0, LW, 2, 0, 0, x(2, 0, 2, 1, 0, 0, 0, 5'b00000));
    add("lw_rd",    0, LW, 2, 0, 1, x(3, 0, 0, 0, 0, 1, 0, 5'b00000));
    add("lw_wb",    0, LW, 2, 0, 0, x(4, 0, 0, 0, 1, 0, 0, 5'b00100));
    // sw 0x01d3a423
    add("sw_fetch", 0, SW, 2, 0, 0, x(0, 1, 0, 2, 2, 0, 0, 5'b11000));
    add("sw_dec",   0, SW, 2, 0, 0, x(1, 1, 1, 1, 0, 0, 0, 5'b00000));
    add("sw_adr",   0, SW, 2, 0, 1, x(2, 1, 2, 1, 0, 0, 0, 5'b00000));
    add("sw_wr",    0, SW, 2, 0, 0, x(5, 1, 0, 0, 0, 1, 0, 5'b00010));
    // beq 0x000e8e63 taken, then not taken
    add("beqt_fetch", 0, BEQ, 0, 0, 0, x(0, 2, 0, 2, 2, 0, 0, 5'b11000));
    add("beqt_dec",   0, BEQ, 0, 0, 1, x(1, 2, 1, 1, 0, 0, 0, 5'b00000));
    add("beqt_beq",   0, BEQ, 0, 0, 1, x(10, 2, 2, 0, 0, 0, 1, 5'b01000));
    add("beqn_fetch", 0, BEQ, 0, 0, 0, x(0, 2, 0, 2, 2, 0, 0, 5'b11000));
    add("beqn_dec",   0, BEQ, 0, 0, 1, x(1, 2, 1, 1, 0, 0, 0, 5'b00000));
    add("beqn_beq",   0, BEQ, 0, 0, 0, x(10, 2, 2, 0, 0, 0, 1, 5'b00000));
    // jal 0x008000ef
    add("jal_fetch", 0, JAL, 0, 0, 0, x(0, 3, 0, 2, 2, 0, 0, 5'b11000));
    add("jal_dec",   0, JAL, 0, 0, 0, x(1, 3, 1, 1, 0, 0, 0, 5'b00000));
    add("jal_jal",   0, JAL, 0, 0, 0, x(9, 3, 1, 2, 0, 0, 0, 5'b01000));
    add("jal_wb",    0, JAL, 0, 0, 1, x(7, 3, 0, 0, 0, 0, 0, 5'b00100));
    // R-type sub
    add("sub_fetch", 0, RT, 0, 1, 0, x(0, 0, 0, 2, 2, 0, 0, 5'b11000));
    add("sub_dec",   0, RT, 0, 1, 0, x(1, 0, 1, 1, 0, 0, 0, 5'b00000));
    add("sub_exe",   0, RT, 0, 1, 0, x(6, 0, 2, 0, 0, 0, 1, 5'b00000));
    add("sub_wb",    0, RT, 0, 1, 0, x(7, 0, 0, 0, 0, 0, 0, 5'b00100));
    // addi with instr[30] set must still add
    add("addi_fetch", 0, IT, 0, 1, 0, x(0, 0, 0, 2, 2, 0, 0, 5'b11000));
    add("addi_dec",   0, IT, 0, 1, 0, x(1, 0, 1, 1, 0, 0, 0, 5'b00000));
    add("addi_exe",   0, IT, 0, 1, 0, x(8, 0, 2, 1, 0, 0, 0, 5'b00000));
    add("addi_wb",    0, IT, 0, 1, 0, x(7, 0, 0, 0, 0, 0, 0, 5'b00100));
    // slt (R), ori (I), and (R), xor-class funct3 falls back to add
    add("slt_fetch", 0, RT, 2, 0, 0, x(0, 0, 0, 2, 2, 0, 0, 5'b11000));
    add("slt_dec",   0, RT, 2, 0, 0, x(1, 0, 1, 1, 0, 0, 0, 5'b00000));
    add("slt_exe",   0, RT, 2, 0, 0, x(6, 0, 2, 0, 0, 0, 5, 5'b00000));
    add("slt_wb",    0, RT, 2, 0, 0, x(7, 0, 0, 0, 0, 0, 0, 5'b00100));
    add("ori_fetch", 0, IT, 6, 0, 0, x(0, 0, 0, 2, 2, 0, 0, 5'b11000));
    add("ori_dec",   0, IT, 6, 0, 0, x(1, 0, 1, 1, 0, 0, 0, 5'b00000));
    add("ori_exe",   0, IT, 6, 0, 0, x(8, 0, 2, 1, 0, 0, 3, 5'b00000));
    add("ori_wb",    0, IT, 6, 0, 0, x(7, 0, 0, 0, 0, 0, 0, 5'b00100));
    add("and_fetch", 0, RT, 7, 0, 0, x(0, 0, 0, 2, 2, 0, 0, 5'b11000));
    add("and_dec",   0, RT, 7, 0, 0, x(1, 0, 1, 1, 0, 0, 0, 5'b00000));
    add("and_exe",   0, RT, 7, 0, 0, x(6, 0, 2, 0, 0, 0, 2, 5'b00000));
    add("and_wb",    0, RT, 7, 0, 0, x(7, 0, 0, 0, 0, 0, 0, 5'b00100));
    add("f4_fetch",  0, RT, 4, 1, 0, x(0, 0, 0, 2, 2, 0, 0, 5'b11000));
    add("f4_dec",    0, RT, 4, 1, 0, x(1, 0, 1, 1, 0, 0, 0, 5'b00000));
    add("f4_exe",    0, RT, 4, 1, 0, x(6, 0, 2, 0, 0, 0, 0, 5'b00000));
    add("f4_wb",     0, RT, 4, 1, 0, x(7, 0, 0, 0, 0, 0, 0, 5'b00100));

    reset    = 1'b1;
    op       = LW;
    funct3   = 3'b010;
    funct7b5 = 1'b0;
    zero     = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < n_rows; i++) begin
      step(tbl[i]);
    end

    // Reset during MEMREAD of lw aborts without writeback; then an illegal opcode.
    step('{"ab_fetch", 1'b0, LW, 3'd2, 1'b0, 1'b0, x(0, 0, 0, 2, 2, 0, 0, 5'b11000)});
    step('{"ab_dec",   1'b0, LW, 3'd2, 1'b0, 1'b0, x(1, 0, 1, 1, 0, 0, 0, 5'b00000)});
    step('{"ab_adr",   1'b0, LW, 3'd2, 1'b0, 1'b0, x(2, 0, 2, 1, 0, 0, 0, 5'b00000)});
    step('{"ab_rd",    1'b1, LW, 3'd2, 1'b0, 1'b0, x(3, 0, 0, 0, 0, 1, 0, 5'b00000)});
    step('{"ill_fetch", 1'b0, ILL0, 3'd0, 1'b0, 1'b0, x(0, 0, 0, 2, 2, 0, 0, 5'b11000)});
    step('{"ill_dec",   1'b0, ILL0, 3'd0, 1'b0, 1'b0, x(1, 0, 1, 1, 0, 0, 0, 5'b00001)});
    step('{"ill_after", 1'b0, ILL0, 3'd0, 1'b0, 1'b0, x(0, 0, 0, 2, 2, 0, 0, 5'b11000)});
    step('{"ill_dec2",  1'b0, ILL0, 3'd0, 1'b0, 1'b0, x(1, 0, 1, 1, 0, 0, 0, 5'b00001)});

    // Reset during MEMWRITE of sw suppresses the store.
    step('{"sa_fetch", 1'b0, SW, 3'd2, 1'b0, 1'b0, x(0, 1, 0, 2, 2, 0, 0, 5'b11000)});
    step('{"sa_dec",   1'b0, SW, 3'd2, 1'b0, 1'b0, x(1, 1, 1, 1, 0, 0, 0, 5'b00000)});
    step('{"sa_adr",   1'b0, SW, 3'd2, 1'b0, 1'b0, x(2, 1, 2, 1, 0, 0, 0, 5'b00000)});
    step('{"sa_wr",    1'b1, SW, 3'd2, 1'b0, 1'b0, x(5, 1, 0, 0, 0, 1, 0, 5'b00000)});

    // Reset during DECODE of an unsupported opcode suppresses the illegal pulse.
    step('{"ir_fetch", 1'b0, ILL1, 3'd0, 1'b0, 1'b0, x(0, 0, 0, 2, 2, 0, 0, 5'b11000)});
    step('{"ir_dec",   1'b1, ILL1, 3'd0, 1'b0, 1'b0, x(1, 0, 1, 1, 0, 0, 0, 5'b00000)});
    step('{"ir_after", 1'b0, ILL1, 3'd0, 1'b0, 1'b0, x(0, 0, 0, 2, 2, 0, 0, 5'b11000)});

    repeat (3) begin
      if (q.size() > 0) @(negedge clk);
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left unchecked, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
